// File: rtl/mc_control.sv
// Multicycle ARM-subset control unit: Moore FSM sequencing fetch, decode,
// data-processing, load/store and branch, plus the condition flags register.
module mc_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic        linkSelect,
  output logic        storedCarry,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [3:0]  ALUControl
);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXECR, EXECI, ALUWB,
    MEMADR, MEMRD, MEMWB, MEMWR, BRANCH
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0010;

  state_t     state, next;
  logic [3:0] flags;
  logic       cond_ex;
  logic       pcw, irw, rw, mw;
  logic       n, z, c, v;
  logic       rd_pc;
  logic       unused;

  assign {n, z, c, v} = flags;
  assign rd_pc        = (Instr[15:12] == 4'hF);
  assign unused       = ^{Instr[19:16], Instr[11:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      flags <= 4'b0000;
    else if (state == ALUWB && Instr[20])
      flags <= ALUFlags;
  end

  always_comb begin
    cond_ex = 1'b0;
    case (Instr[31:28])
      4'h0: cond_ex = z;
      4'h1: cond_ex = !z;
      4'h2: cond_ex = c;
      4'h3: cond_ex = !c;
      4'h4: cond_ex = n;
      4'h5: cond_ex = !n;
      4'h6: cond_ex = v;
      4'h7: cond_ex = !v;
      4'h8: cond_ex = c && !z;
      4'h9: cond_ex = !c || z;
      4'hA: cond_ex = (n == v);
      4'hB: cond_ex = (n != v);
      4'hC: cond_ex = !z && (n == v);
      4'hD: cond_ex = z || (n != v);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    next       = state;
    pcw        = 1'b0;
    irw        = 1'b0;
    rw         = 1'b0;
    mw         = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    linkSelect = 1'b0;
    RegSrc     = 2'b00;
    ImmSrc     = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = OP_ADD;
    unique case (state)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irw       = MemReady;
        pcw       = MemReady;
        if (MemReady) next = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (!cond_ex)
          next = FETCH;
        else begin
          unique case (Instr[27:26])
            2'b00:   next = Instr[25] ? EXECI : EXECR;
            2'b01:   next = MEMADR;
            2'b10:   next = BRANCH;
            default: next = FETCH;
          endcase
        end
      end
      EXECR: begin
        ALUControl = Instr[24:21];
        next       = ALUWB;
      end
      EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = Instr[24:21];
        next       = ALUWB;
      end
      ALUWB: begin
        // compare/test opcodes only update flags
        rw   = (Instr[24:23] != 2'b10);
        pcw  = rw && rd_pc;
        next = FETCH;
      end
      MEMADR: begin
        ALUSrcB    = 2'b01;
        ImmSrc     = 2'b01;
        RegSrc     = 2'b10;
        ALUControl = Instr[23] ? OP_ADD : OP_SUB;
        next       = Instr[20] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
        if (MemReady) next = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        rw        = 1'b1;
        pcw       = rd_pc;
        next      = FETCH;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        RegSrc = 2'b10;
        mw     = 1'b1;
        if (MemReady) next = FETCH;
      end
      BRANCH: begin
        RegSrc     = 2'b01;
        ALUSrcB    = 2'b01;
        ImmSrc     = 2'b10;
        ResultSrc  = 2'b10;
        pcw        = 1'b1;
        linkSelect = Instr[24];
        rw         = Instr[24];
        next       = FETCH;
      end
      default: next = FETCH;
    endcase
  end

  // reset blocks every write strobe immediately, not at the next edge
  assign PCWrite     = pcw & reset;
  assign IRWrite     = irw & reset;
  assign RegWrite    = rw & reset;
  assign MemWrite    = mw & reset;
  assign storedCarry = flags[1];

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port Instr  input  32  instruction register contents (cond, class, I, opcode, S, Rd, offsets).
REQ-004 SHALL have port ALUFlags  input  4  datapath flags {N,Z,C,V}.
REQ-005 SHALL have port MemReady  input  1  memory completes the current access this cycle.
REQ-006 SHALL have outputs PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, linkSelect, storedCarry (1 each) and RegSrc, ImmSrc, ALUSrcB, ResultSrc (2 each).
REQ-007 SHALL have output ALUControl  4  ARM data-processing opcode to the ALU (ADD=0100, SUB=0010).

Function
REQ-008 SHALL implement a Moore FSM with states FETCH, DECODE, EXECR, EXECI, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH; every output not listed for a state is 0, ALUControl defaults to ADD.
REQ-009 FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=PCWrite=MemReady; stay while MemReady=0, else go to DECODE.
REQ-010 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10; if CondEx=0 -> FETCH; else Instr[27:26]=00 -> Instr[25]?EXECI:EXECR, 01 -> MEMADR, 10 -> BRANCH, 11 -> FETCH (no-op).
REQ-011 CondEx SHALL be evaluated on Instr[31:28] against the internal flags register per the 15 ARM conditions (EQ..AL); 1111 SHALL be treated as never-execute.
REQ-012 EXECR: ALUSrcB=00, ALUControl=Instr[24:21] -> ALUWB; EXECI: ALUSrcB=01, ImmSrc=00, ALUControl=Instr[24:21] -> ALUWB.
REQ-013 ALUWB: ResultSrc=00; RegWrite=1 unless Instr[24:23]=10 (TST/TEQ/CMP/CMN); PCWrite=1 when RegWrite=1 and Instr[15:12]=1111; -> FETCH.
REQ-014 Flags register SHALL load ALUFlags at the clock edge ending ALUWB when Instr[20]=1, and at no other time.
REQ-015 MEMADR: ALUSrcB=01, ImmSrc=01, ALUControl=Instr[23]?ADD:SUB, RegSrc[1]=1; Instr[20]=1 -> MEMRD else -> MEMWR.
REQ-016 MEMRD: AdrSrc=1; stay while MemReady=0, else -> MEMWB.
REQ-017 MEMWB: ResultSrc=01, RegWrite=1, PCWrite=1 if Instr[15:12]=1111; -> FETCH.
REQ-018 MEMWR: AdrSrc=1, RegSrc[1]=1, MemWrite held 1 until the MemReady cycle inclusive; -> FETCH on MemReady.
REQ-019 BRANCH: RegSrc[0]=1, ALUSrcB=01, ImmSrc=10, ResultSrc=10, PCWrite=1; if Instr[24]=1 also linkSelect=1 and RegWrite=1; -> FETCH.
REQ-020 storedCarry SHALL equal the registered C flag at all times.
REQ-021 Instr SHALL be sampled combinationally only in DECODE through the last state of the instruction; changes to Instr during FETCH SHALL not affect outputs.
REQ-022 Per-instruction latency (MemReady always 1): DP 4 cycles, LDR 5, STR 4, B/BL 3, condition-failed 2.

Reset
REQ-023 While reset=0, state SHALL be FETCH, flags SHALL be 0000, and PCWrite, IRWrite, RegWrite, MemWrite SHALL be forced 0 regardless of MemReady.
REQ-024 Reset asserted mid-instruction SHALL abandon it immediately with no further register, PC, flag, or memory write; first FETCH begins on the first edge after release.

Verification
REQ-025 Reset release, MemReady=1, Instr=E2811005 (ADD R1,R1,#5) -> FETCH,DECODE,EXECI,ALUWB; RegWrite=1 only in ALUWB; ALUControl=0100 in EXECI.
REQ-026 Instr=E3510000 (CMP R1,#0), ALUFlags=0100 -> ALUWB with RegWrite=0, flags=0100; then Instr=0A000002 (BEQ) -> BRANCH with PCWrite=1, linkSelect=0.
REQ-027 Flags Z=0, Instr=0A000002 -> DECODE then FETCH; no PCWrite outside FETCH, 2 cycles total.
REQ-028 Instr=E5912000 (LDR) with MemReady low 3 cycles in MEMRD -> stays MEMRD with AdrSrc=1, then MEMWB RegWrite=1, ResultSrc=01.
REQ-029 Instr=E5812000 (STR), MemReady low 2 cycles -> MemWrite=1 for 3 cycles, RegSrc[1]=1; Instr=EB000010 (BL) -> RegWrite=1, linkSelect=1.
REQ-030 reset=0 asserted during MEMWR -> MemWrite drops to 0 asynchronously, state FETCH, flags 0000.
